// File: rtl/y86_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : y86_mem_port_arbiter
// Description : Shares one byte-wide single-port synchronous memory between the
//               fetch stage (10-byte instruction reads) and the memory stage
//               (8-byte data reads/writes). Each transaction is sequenced one
//               byte per cycle. Fetch bytes are assembled into Byte0/Byte19 and
//               data bytes into a 64-bit little-endian word.
//               Optional feature macro: ARB_FAIRNESS_EN. When it is defined,
//               simultaneous requests alternate between kinds. When it is not
//               defined, data always wins over fetch.
// Revision    : 1.0 - initial release
// ============================================================================
module y86_mem_port_arbiter #(
  parameter int MEM_BYTES = 2048,
  parameter int ADDR_W    = 64
) (
  input  logic                         clk,
  input  logic                         rst_n,
  // fetch port
  input  logic                         f_req,
  input  logic [ADDR_W-1:0]            f_pc,
  output logic                         f_ack,
  output logic                         imem_error,
  output logic [7:0]                   Byte0,
  output logic [71:0]                  Byte19,
  // data port
  input  logic                         d_req,
  input  logic                         d_we,
  input  logic [ADDR_W-1:0]            d_addr,
  input  logic [63:0]                  d_wdata,
  output logic                         d_ack,
  output logic                         dmem_error,
  output logic [63:0]                  d_rdata,
  // memory port
  output logic [$clog2(MEM_BYTES)-1:0] mem_addr,
  output logic                         mem_we,
  output logic [7:0]                   mem_wdata,
  input  logic [7:0]                   mem_rdata
);

  localparam int c_AW = $clog2(MEM_BYTES);

  localparam logic [2:0] c_IDLE = 3'd0;
  localparam logic [2:0] c_F_RD = 3'd1;
  localparam logic [2:0] c_D_RD = 3'd2;
  localparam logic [2:0] c_D_WR = 3'd3;
  localparam logic [2:0] c_ACK  = 3'd4;

  localparam logic [3:0] c_F_LEN = 4'd10;
  localparam logic [3:0] c_D_LEN = 4'd8;

  // Highest legal byte address, widened by one bit so that base+N-1 can never
  // wrap: any carry out of ADDR_W bits lands above this limit.
  localparam logic [ADDR_W:0] c_LAST_ADDR = (ADDR_W + 1)'(MEM_BYTES - 1);

  logic [2:0]      r_state;
  logic [3:0]      r_cnt;
  logic [c_AW-1:0] r_base;
  logic            r_kind_d;   // 1 = data transaction, 0 = fetch
  logic            r_err;
  logic [79:0]     r_buf;      // byte i at [8i+7:8i]; holds write data for D_WR
  logic [7:0]      r_byte0;
  logic [71:0]     r_byte19;
  logic [63:0]     r_rdata;

  logic [ADDR_W:0] w_f_end;
  logic [ADDR_W:0] w_d_end;
  logic            w_f_err;
  logic            w_d_err;
  logic            w_grant_d;
  logic            w_grant_f;
  logic            w_err;
  logic [3:0]      w_len;
  logic [79:0]     w_buf_next;
  logic [71:0]     w_byte19_next;
  logic [7:0]      w_wbyte;

  // Span checks: last byte of the transaction must lie inside the memory.
  assign w_f_end = {1'b0, f_pc}   + (ADDR_W + 1)'(c_F_LEN - 4'd1);
  assign w_d_end = {1'b0, d_addr} + (ADDR_W + 1)'(c_D_LEN - 4'd1);
  assign w_f_err = (w_f_end > c_LAST_ADDR);
  assign w_d_err = (w_d_end > c_LAST_ADDR);

`ifdef ARB_FAIRNESS_EN
  logic r_last_grant_d;   // 1 = last grant went to data

  // With both requests pending, hand the port to the kind that waited last.
  assign w_grant_d = (d_req && f_req) ? !r_last_grant_d : d_req;

  // Remember which kind was granted most recently.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_grant_d <= 1'b0;
    end else if (r_state == c_IDLE && (d_req || f_req)) begin
      r_last_grant_d <= w_grant_d;
    end
  end
`else
  // Fixed priority: data always beats fetch.
  assign w_grant_d = d_req;
`endif

  assign w_grant_f = f_req && !w_grant_d;
  assign w_err     = w_grant_d ? w_d_err : w_f_err;
  assign w_len     = r_kind_d ? c_D_LEN : c_F_LEN;

  // Read buffer with the byte returned this cycle merged in (byte cnt-1).
  always_comb begin
    w_buf_next = r_buf;
    for (int i = 0; i < 10; i++) begin
      if (r_cnt == 4'(i + 1)) begin
        w_buf_next[8*i +: 8] = mem_rdata;
      end
    end
  end

  // Byte19 packs bytes 1..9 with byte 1 in the most significant position.
  always_comb begin
    w_byte19_next = '0;
    for (int i = 1; i < 10; i++) begin
      w_byte19_next[8*(9-i) +: 8] = w_buf_next[8*i +: 8];
    end
  end

  // Select the write byte indexed by the current count.
  always_comb begin
    w_wbyte = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (r_cnt == 4'(i)) begin
        w_wbyte = r_buf[8*i +: 8];
      end
    end
  end

  // Memory port: address only while a byte is being issued, strobe only in D_WR.
  always_comb begin
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_wdata = 8'h00;
    case (r_state)
      c_F_RD, c_D_RD: begin
        if (r_cnt < w_len) begin
          mem_addr = r_base + c_AW'(r_cnt);
        end
      end
      c_D_WR: begin
        mem_addr  = r_base + c_AW'(r_cnt);
        mem_we    = 1'b1;
        mem_wdata = w_wbyte;
      end
      default: begin
        mem_addr = '0;
      end
    endcase
  end

  // Transaction sequencer: grant, byte stepping, result publication.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= c_IDLE;
      r_cnt    <= 4'd0;
      r_base   <= '0;
      r_kind_d <= 1'b0;
      r_err    <= 1'b0;
      r_buf    <= '0;
      r_byte0  <= 8'h00;
      r_byte19 <= '0;
      r_rdata  <= '0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (w_grant_d || w_grant_f) begin
            r_kind_d <= w_grant_d;
            r_cnt    <= 4'd0;
            r_base   <= w_grant_d ? d_addr[c_AW-1:0] : f_pc[c_AW-1:0];
            r_buf    <= {16'h0000, d_wdata};
            r_err    <= w_err;
            if (w_err) begin
              // Out-of-range: no memory access, result data reads as zero.
              r_state <= c_ACK;
              if (w_grant_d) begin
                r_rdata <= '0;
              end else begin
                r_byte0  <= 8'h00;
                r_byte19 <= '0;
              end
            end else if (w_grant_d) begin
              r_state <= d_we ? c_D_WR : c_D_RD;
            end else begin
              r_state <= c_F_RD;
            end
          end
        end
        c_F_RD, c_D_RD: begin
          r_buf <= w_buf_next;
          if (r_cnt == w_len) begin
            r_state <= c_ACK;
            if (r_kind_d) begin
              r_rdata <= w_buf_next[63:0];
            end else begin
              r_byte0  <= w_buf_next[7:0];
              r_byte19 <= w_byte19_next;
            end
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        c_D_WR: begin
          if (r_cnt == c_D_LEN - 4'd1) begin
            r_state <= c_ACK;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        c_ACK: begin
          r_state <= c_IDLE;
        end
        default: begin
          r_state <= c_IDLE;
        end
      endcase
    end
  end

  assign f_ack      = (r_state == c_ACK) && !r_kind_d;
  assign d_ack      = (r_state == c_ACK) &&  r_kind_d;
  assign imem_error = f_ack && r_err;
  assign dmem_error = d_ack && r_err;
  assign Byte0      = r_byte0;
  assign Byte19     = r_byte19;
  assign d_rdata    = r_rdata;

endmodule
`default_nettype wire

// File: tb/tb_y86_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_y86_mem_port_arbiter
// Description : Directed self-checking bench for y86_mem_port_arbiter with a
//               byte-wide synchronous memory model (1-cycle read latency).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_y86_mem_port_arbiter;

  localparam int MEM_BYTES = 2048;
  localparam int ADDR_W    = 64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        f_req = 1'b0;
  logic [63:0] f_pc = '0;
  logic        f_ack;
  logic        imem_error;
  logic [7:0]  Byte0;
  logic [71:0] Byte19;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [63:0] d_addr = '0;
  logic [63:0] d_wdata = '0;
  logic        d_ack;
  logic        dmem_error;
  logic [63:0] d_rdata;
  logic [10:0] mem_addr;
  logic        mem_we;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata = 8'h00;

  logic [7:0]  mem [MEM_BYTES];

  int n_chk  = 0;
  int n_fail = 0;

  y86_mem_port_arbiter #(.MEM_BYTES(MEM_BYTES), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .f_req(f_req), .f_pc(f_pc), .f_ack(f_ack), .imem_error(imem_error),
    .Byte0(Byte0), .Byte19(Byte19),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .dmem_error(dmem_error), .d_rdata(d_rdata),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Synchronous byte memory: write on strobe, registered read.
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  task automatic check_eq(input string tag, input logic [79:0] act, input logic [79:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // One transaction; cyc counts rising edges from the sampling IDLE edge to ack.
  task automatic run_txn(input bit is_d, input bit we, input logic [63:0] addr,
                         input logic [63:0] wd, output int cyc, output bit err,
                         output bit touched);
    cyc = 0; err = 0; touched = 0;
    if (is_d) begin d_req = 1; d_we = we; d_addr = addr; d_wdata = wd; end
    else begin f_req = 1; f_pc = addr; end
    while (cyc < 40) begin
      @(posedge clk); cyc++;
      @(negedge clk);
      if (mem_we || mem_addr != 0) touched = 1;
      if (is_d ? d_ack : f_ack) begin
        err = is_d ? dmem_error : imem_error;
        break;
      end
    end
    d_req = 0; f_req = 0;
    @(negedge clk);
  endtask

  // Simultaneous fetch(112) + data read(200); reports which ack came first.
  task automatic run_pair(output bit data_first, output logic [1:0] done);
    bit got_d = 0, got_f = 0;
    data_first = 0;
    f_req = 1; f_pc = 112; d_req = 1; d_we = 0; d_addr = 200;
    for (int i = 0; i < 60 && !(got_d && got_f); i++) begin
      @(posedge clk); @(negedge clk);
      if (d_ack) begin if (!got_f) data_first = 1; got_d = 1; d_req = 0; end
      if (f_ack) begin got_f = 1; f_req = 0; end
    end
    d_req = 0; f_req = 0;
    done = {got_d, got_f};
    @(negedge clk);
  endtask

  int          cyc;
  bit          err, touched, dfirst;
  logic [1:0]  done;
  int          acks;

  initial begin
    for (int i = 0; i < MEM_BYTES; i++) mem[i] = 8'h00;
    mem[112] = 8'h30; mem[113] = 8'hF8; mem[114] = 8'h08;
    for (int i = 0; i < 10; i++) mem[2038 + i] = 8'(8'hC0 + i);
    for (int i = 0; i < 8; i++)  mem[300 + i]  = 8'hEE;

    // Reset state
    repeat (3) @(negedge clk);
    check_eq("rst_f_ack",  {79'b0, f_ack}, 80'd0);
    check_eq("rst_d_ack",  {79'b0, d_ack}, 80'd0);
    check_eq("rst_mem_we", {79'b0, mem_we}, 80'd0);
    check_eq("rst_byte19", {8'b0, Byte19}, 80'd0);
    check_eq("rst_rdata",  {16'b0, d_rdata}, 80'd0);
    rst_n = 1;
    @(negedge clk);

    // Fetch at 112
    run_txn(0, 0, 112, 0, cyc, err, touched);
    check_eq("f112_lat",  80'(cyc), 80'd12);
    check_eq("f112_err",  {79'b0, err}, 80'd0);
    check_eq("f112_b0",   {72'b0, Byte0}, 80'h30);
    check_eq("f112_b19",  {8'b0, Byte19}, {8'b0, 72'hF8_08_00_00_00_00_00_00_00});

    // Data write at 200 then read back
    run_txn(1, 1, 200, 64'h1122334455667788, cyc, err, touched);
    check_eq("dw200_lat", 80'(cyc), 80'd9);
    check_eq("dw200_m0",  {72'b0, mem[200]}, 80'h88);
    check_eq("dw200_m7",  {72'b0, mem[207]}, 80'h11);
    run_txn(1, 0, 200, 0, cyc, err, touched);
    check_eq("dr200_lat", 80'(cyc), 80'd10);
    check_eq("dr200_dat", {16'b0, d_rdata}, {16'b0, 64'h1122334455667788});

    // Fetch span boundary
    run_txn(0, 0, 2039, 0, cyc, err, touched);
    check_eq("f2039_lat", 80'(cyc), 80'd1);
    check_eq("f2039_err", {79'b0, err}, 80'd1);
    check_eq("f2039_mem", {79'b0, touched}, 80'd0);
    check_eq("f2039_b0",  {72'b0, Byte0}, 80'd0);
    run_txn(0, 0, 2038, 0, cyc, err, touched);
    check_eq("f2038_lat", 80'(cyc), 80'd12);
    check_eq("f2038_err", {79'b0, err}, 80'd0);
    check_eq("f2038_b0",  {72'b0, Byte0}, 80'hC0);
    check_eq("f2038_b19", {8'b0, Byte19}, {8'b0, 72'hC1C2C3C4C5C6C7C8C9});
    check_eq("hold_rdata", {16'b0, d_rdata}, {16'b0, 64'h1122334455667788});

    // Data span boundary
    run_txn(1, 0, 2040, 0, cyc, err, touched);
    check_eq("d2040_lat", 80'(cyc), 80'd10);
    check_eq("d2040_dat", {16'b0, d_rdata}, {16'b0, 64'hC9C8C7C6C5C4C3C2});
    run_txn(1, 0, 2041, 0, cyc, err, touched);
    check_eq("d2041_lat", 80'(cyc), 80'd1);
    check_eq("d2041_err", {79'b0, err}, 80'd1);
    check_eq("d2041_dat", {16'b0, d_rdata}, 80'd0);
    run_txn(1, 1, 64'hFFFF_FFFF_FFFF_FFFC, 64'hDEAD, cyc, err, touched);
    check_eq("dwrap_err", {79'b0, err}, 80'd1);
    check_eq("dwrap_mem", {79'b0, touched}, 80'd0);

    // Drop d_req mid read: exactly one ack, no regrant
    acks = 0;
    d_req = 1; d_we = 0; d_addr = 200;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk); @(negedge clk);
      if (i == 3) d_req = 0;
      if (d_ack) acks++;
    end
    check_eq("drop_acks", 80'(acks), 80'd1);

    // Reset during D_WR while cnt=4
    d_req = 1; d_we = 1; d_addr = 300; d_wdata = 64'h0807060504030201;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check_eq("rwr_we_on", {79'b0, mem_we}, 80'd1);
    rst_n = 0;
    #1;
    check_eq("rwr_we_off", {79'b0, mem_we}, 80'd0);
    d_req = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
    acks = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); @(negedge clk);
      if (d_ack) acks++;
    end
    check_eq("rwr_noack", 80'(acks), 80'd0);
    check_eq("rwr_m300", {72'b0, mem[300]}, 80'h01);
    check_eq("rwr_m303", {72'b0, mem[303]}, 80'h04);
    check_eq("rwr_m304", {72'b0, mem[304]}, 80'hEE);
    check_eq("rwr_m307", {72'b0, mem[307]}, 80'hEE);

    // Simultaneous requests after reset: data first in both builds
    run_pair(dfirst, done);
    check_eq("pairA_done",  {78'b0, done}, 80'd3);
    check_eq("pairA_first", {79'b0, dfirst}, 80'd1);
    run_pair(dfirst, done);
    check_eq("pairB_first", {79'b0, dfirst}, 80'd1);
    // A lone data grant leaves data as the most recent winner
    run_txn(1, 1, 400, 64'h55, cyc, err, touched);
    run_pair(dfirst, done);
    check_eq("pairC_done",  {78'b0, done}, 80'd3);
`ifdef ARB_FAIRNESS_EN
    check_eq("pairC_first", {79'b0, dfirst}, 80'd0);
`else
    check_eq("pairC_first", {79'b0, dfirst}, 80'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
